// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, logical shift both ways, rotate both ways,
// arithmetic shift right, parallel load and clear. A saturating shift counter
// and a one-cycle completion pulse let it serve directly as a serialiser or
// deserialiser.
module univ_shift_reg #(
   parameter int unsigned             WIDTH   = 8,
   parameter logic [WIDTH-1:0]        RST_VAL = '0
) (
   input  logic                        sys_clk,
   input  logic                        sys_rst,
   input  logic                        en,
   input  logic [2:0]                  mode,
   input  logic [WIDTH-1:0]            d,
   input  logic                        ser_in_msb,
   input  logic                        ser_in_lsb,
   output logic [WIDTH-1:0]            q,
   output logic                        ser_out_msb,
   output logic                        ser_out_lsb,
   output logic [$clog2(WIDTH+1)-1:0]  shift_cnt,
   output logic                        done
);

   localparam int unsigned CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   // Mode encodings; values are fixed by the external interface.
   localparam logic [2:0] M_HOLD  = 3'b000;
   localparam logic [2:0] M_SHR   = 3'b001;
   localparam logic [2:0] M_SHL   = 3'b010;
   localparam logic [2:0] M_ROR   = 3'b011;
   localparam logic [2:0] M_ROL   = 3'b100;
   localparam logic [2:0] M_LOAD  = 3'b101;
   localparam logic [2:0] M_ASR   = 3'b110;
   localparam logic [2:0] M_CLEAR = 3'b111;

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] q_next;
   logic [CW-1:0]    cnt_r;
   logic [CW-1:0]    cnt_next;
   logic             done_r;
   logic             done_next;
   logic             is_shift;

   // Shift-class modes advance the counter; LOAD/CLEAR restart it; HOLD leaves it.
   always_comb begin
      is_shift = 1'b0;
      case (mode)
         M_SHR, M_SHL, M_ROR, M_ROL, M_ASR: is_shift = 1'b1;
         default:                           is_shift = 1'b0;
      endcase
   end

   // Next-state data path and counter/pulse generation for the enabled case.
   always_comb begin
      q_next    = q_r;
      cnt_next  = cnt_r;
      done_next = 1'b0;
      if (en) begin
         case (mode)
            M_HOLD:  q_next = q_r;
            M_SHR:   q_next = {ser_in_msb, q_r[WIDTH-1:1]};
            M_SHL:   q_next = {q_r[WIDTH-2:0], ser_in_lsb};
            M_ROR:   q_next = {q_r[0], q_r[WIDTH-1:1]};
            M_ROL:   q_next = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
            M_LOAD:  q_next = d;
            M_ASR:   q_next = {q_r[WIDTH-1], q_r[WIDTH-1:1]};
            M_CLEAR: q_next = RST_VAL;
            default: q_next = q_r;
         endcase

         if (mode == M_LOAD || mode == M_CLEAR) begin
            cnt_next = '0;
         end else if (is_shift && cnt_r < CNT_MAX) begin
            // Pulse only on the WIDTH-1 -> WIDTH transition, so saturation never re-fires.
            cnt_next  = cnt_r + 1'b1;
            done_next = (cnt_r == CNT_LAST);
         end
      end
   end

   // Register update with synchronous reset overriding enable and mode.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         q_r    <= RST_VAL;
         cnt_r  <= '0;
         done_r <= 1'b0;
      end else begin
         q_r    <= q_next;
         cnt_r  <= cnt_next;
         done_r <= done_next;
      end
   end

   assign q           = q_r;
   assign ser_out_msb = q_r[WIDTH-1];
   assign ser_out_lsb = q_r[0];
   assign shift_cnt   = cnt_r;
   assign done        = done_r;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8). A second instance with a
// non-zero RST_VAL shares all inputs to confirm reset/clear use the parameter.
module tb_univ_shift_reg;

   localparam logic [2:0] M_HOLD  = 3'b000;
   localparam logic [2:0] M_SHR   = 3'b001;
   localparam logic [2:0] M_SHL   = 3'b010;
   localparam logic [2:0] M_ROR   = 3'b011;
   localparam logic [2:0] M_ROL   = 3'b100;
   localparam logic [2:0] M_LOAD  = 3'b101;
   localparam logic [2:0] M_ASR   = 3'b110;
   localparam logic [2:0] M_CLEAR = 3'b111;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       en = 1'b0;
   logic [2:0] mode = 3'b000;
   logic [7:0] d = 8'h00;
   logic       ser_in_msb = 1'b0;
   logic       ser_in_lsb = 1'b0;

   logic [7:0] q,  q2;
   logic       ser_out_msb, ser_out_lsb, ser_out_msb2, ser_out_lsb2;
   logic [3:0] shift_cnt, shift_cnt2;
   logic       done, done2;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] shr_q   [8] = '{8'h52, 8'h29, 8'h14, 8'h0A, 8'h05, 8'h02, 8'h01, 8'h00};
   logic       shr_lsb [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
   logic [7:0] asr_q   [3] = '{8'hC8, 8'hE4, 8'hF2};
   logic [7:0] asr2_q  [5] = '{8'hF2, 8'hF9, 8'hFC, 8'hFE, 8'hFF};

   always #5 sys_clk = ~sys_clk;

   univ_shift_reg #(.WIDTH(8), .RST_VAL(8'h00)) u_dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .mode(mode), .d(d),
      .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .q(q),
      .ser_out_msb(ser_out_msb), .ser_out_lsb(ser_out_lsb),
      .shift_cnt(shift_cnt), .done(done)
   );

   univ_shift_reg #(.WIDTH(8), .RST_VAL(8'hC3)) u_dut2 (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .mode(mode), .d(d),
      .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .q(q2),
      .ser_out_msb(ser_out_msb2), .ser_out_lsb(ser_out_lsb2),
      .shift_cnt(shift_cnt2), .done(done2)
   );

   // Inputs change and outputs are sampled 1 time unit after the rising edge.
   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic op(input logic [2:0] m, input logic [7:0] dv);
      en   = 1'b1;
      mode = m;
      d    = dv;
      tick();
   endtask

   task automatic test_reset();
      sys_rst = 1'b1; en = 1'b1; mode = M_LOAD; d = 8'hFF;
      tick(); tick();
      n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL rst_q got=%h exp=00", q); end
      n_cmp++; if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL rst_cnt got=%0d exp=0", shift_cnt); end
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b exp=0", done); end
      n_cmp++; if (q2 !== 8'hC3) begin n_err++; $display("FAIL rst_q2 got=%h exp=c3", q2); end
      sys_rst = 1'b0;
      #3;
      n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL rst_release_midcycle got=%h exp=00", q); end
      tick();
      n_cmp++; if (q !== 8'hFF) begin n_err++; $display("FAIL load_after_rst got=%h exp=ff", q); end
      mode = M_HOLD; sys_rst = 1'b1;
      #3;
      n_cmp++; if (q !== 8'hFF) begin n_err++; $display("FAIL rst_assert_midcycle got=%h exp=ff", q); end
      tick();
      n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL rst_again_q got=%h exp=00", q); end
      n_cmp++; if (q2 !== 8'hC3) begin n_err++; $display("FAIL rst_again_q2 got=%h exp=c3", q2); end
      sys_rst = 1'b0;
   endtask

   task automatic test_shr();
      ser_in_msb = 1'b0;
      op(M_LOAD, 8'hA5);
      n_cmp++; if (q !== 8'hA5) begin n_err++; $display("FAIL shr_load got=%h exp=a5", q); end
      n_cmp++; if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL shr_load_cnt got=%0d exp=0", shift_cnt); end
      for (int i = 0; i < 8; i++) begin
         mode = M_SHR;
         n_cmp++; if (ser_out_lsb !== shr_lsb[i]) begin n_err++; $display("FAIL shr_ser_out_lsb step=%0d got=%b exp=%b", i, ser_out_lsb, shr_lsb[i]); end
         tick();
         n_cmp++; if (q !== shr_q[i]) begin n_err++; $display("FAIL shr_q step=%0d got=%h exp=%h", i, q, shr_q[i]); end
         n_cmp++; if (shift_cnt !== 4'(i + 1)) begin n_err++; $display("FAIL shr_cnt step=%0d got=%0d exp=%0d", i, shift_cnt, i + 1); end
         n_cmp++; if (done !== (i == 7)) begin n_err++; $display("FAIL shr_done step=%0d got=%b exp=%b", i, done, (i == 7)); end
      end
      op(M_HOLD, 8'h00);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL shr_done_clears got=%b exp=0", done); end
      n_cmp++; if (shift_cnt !== 4'd8) begin n_err++; $display("FAIL shr_cnt_hold got=%0d exp=8", shift_cnt); end
   endtask

   task automatic test_rotate();
      op(M_LOAD, 8'h81);
      op(M_ROL, 8'h00);
      n_cmp++; if (q !== 8'h03) begin n_err++; $display("FAIL rol_q got=%h exp=03", q); end
      n_cmp++; if (shift_cnt !== 4'd1) begin n_err++; $display("FAIL rol_cnt got=%0d exp=1", shift_cnt); end
      for (int i = 0; i < 8; i++) begin
         op(M_ROR, 8'h00);
         if (i == 0) begin
            n_cmp++; if (q !== 8'h81) begin n_err++; $display("FAIL ror_first_q got=%h exp=81", q); end
            n_cmp++; if (ser_out_msb !== 1'b1) begin n_err++; $display("FAIL ror_ser_out_msb got=%b exp=1", ser_out_msb); end
         end
         n_cmp++; if (shift_cnt !== 4'((i + 2 > 8) ? 8 : i + 2)) begin n_err++; $display("FAIL ror_cnt step=%0d got=%0d", i, shift_cnt); end
         n_cmp++; if (done !== (i == 6)) begin n_err++; $display("FAIL ror_done step=%0d got=%b exp=%b", i, done, (i == 6)); end
      end
      n_cmp++; if (q !== 8'h03) begin n_err++; $display("FAIL ror_full_turn got=%h exp=03", q); end
      n_cmp++; if (ser_out_msb !== 1'b0) begin n_err++; $display("FAIL ror_end_msb got=%b exp=0", ser_out_msb); end
   endtask

   task automatic test_asr();
      op(M_LOAD, 8'h90);
      for (int i = 0; i < 3; i++) begin
         op(M_ASR, 8'h00);
         n_cmp++; if (q !== asr_q[i]) begin n_err++; $display("FAIL asr_q step=%0d got=%h exp=%h", i, q, asr_q[i]); end
         n_cmp++; if (shift_cnt !== 4'(i + 1)) begin n_err++; $display("FAIL asr_cnt step=%0d got=%0d exp=%0d", i, shift_cnt, i + 1); end
      end
      ser_in_lsb = 1'b1;
      op(M_SHL, 8'h00);
      ser_in_lsb = 1'b0;
      n_cmp++; if (q !== 8'hE5) begin n_err++; $display("FAIL shl_q got=%h exp=e5", q); end
      for (int i = 0; i < 5; i++) begin
         op(M_ASR, 8'h00);
         n_cmp++; if (q !== asr2_q[i]) begin n_err++; $display("FAIL asr_conv step=%0d got=%h exp=%h", i, q, asr2_q[i]); end
         n_cmp++; if (done !== (i == 3)) begin n_err++; $display("FAIL asr_done step=%0d got=%b exp=%b", i, done, (i == 3)); end
      end
      n_cmp++; if (shift_cnt !== 4'd8) begin n_err++; $display("FAIL asr_sat_cnt got=%0d exp=8", shift_cnt); end
   endtask

   task automatic test_enable_clear();
      op(M_LOAD, 8'h3C);
      en = 1'b0; mode = M_SHR; ser_in_msb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_cmp++; if (q !== 8'h3C) begin n_err++; $display("FAIL en0_q step=%0d got=%h exp=3c", i, q); end
         n_cmp++; if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL en0_cnt step=%0d got=%0d exp=0", i, shift_cnt); end
      end
      op(M_SHR, 8'h00);
      ser_in_msb = 1'b0;
      n_cmp++; if (q !== 8'h9E) begin n_err++; $display("FAIL en1_shr got=%h exp=9e", q); end
      op(M_HOLD, 8'h00);
      n_cmp++; if (q !== 8'h9E) begin n_err++; $display("FAIL hold_q got=%h exp=9e", q); end
      n_cmp++; if (shift_cnt !== 4'd1) begin n_err++; $display("FAIL hold_cnt got=%0d exp=1", shift_cnt); end
      op(M_CLEAR, 8'hFF);
      n_cmp++; if (q !== 8'h00) begin n_err++; $display("FAIL clear_q got=%h exp=00", q); end
      n_cmp++; if (q2 !== 8'hC3) begin n_err++; $display("FAIL clear_q2 got=%h exp=c3", q2); end
      n_cmp++; if (shift_cnt !== 4'd0) begin n_err++; $display("FAIL clear_cnt got=%0d exp=0", shift_cnt); end
   endtask

   task automatic test_reset_midop();
      ser_in_msb = 1'b0;
      op(M_LOAD, 8'hFF);
      for (int i = 0; i < 7; i++) op(M_SHR, 8'h00);
      n_cmp++; if (q !== 8'h01 || shift_cnt !== 4'd7 || done !== 1'b0) begin
         n_err++; $display("FAIL midop_pre got q=%h cnt=%0d done=%b exp q=01 cnt=7 done=0", q, shift_cnt, done);
      end
      sys_rst = 1'b1; en = 1'b1; mode = M_SHR;
      tick();
      sys_rst = 1'b0;
      n_cmp++; if (q !== 8'h00 || shift_cnt !== 4'd0 || done !== 1'b0) begin
         n_err++; $display("FAIL midop_rst got q=%h cnt=%0d done=%b exp q=00 cnt=0 done=0", q, shift_cnt, done);
      end
      op(M_HOLD, 8'h00);
      n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL midop_no_pulse got=%b exp=0", done); end
   endtask

   task automatic test_back_to_back();
      op(M_LOAD, 8'h0F);
      for (int i = 0; i < 7; i++) op(M_ROL, 8'h00);
      n_cmp++; if (q !== 8'h87) begin n_err++; $display("FAIL b2b_rol7 got=%h exp=87", q); end
      op(M_LOAD, 8'h66);
      n_cmp++; if (q !== 8'h66 || shift_cnt !== 4'd0 || done !== 1'b0) begin
         n_err++; $display("FAIL b2b_load got q=%h cnt=%0d done=%b exp q=66 cnt=0 done=0", q, shift_cnt, done);
      end
      ser_in_lsb = 1'b0;
      for (int i = 0; i < 8; i++) op(M_SHL, 8'h00);
      n_cmp++; if (q !== 8'h00 || shift_cnt !== 4'd8 || done !== 1'b1) begin
         n_err++; $display("FAIL b2b_rearm got q=%h cnt=%0d done=%b exp q=00 cnt=8 done=1", q, shift_cnt, done);
      end
      en = 1'b0;
      tick();
      n_cmp++; if (done !== 1'b0 || shift_cnt !== 4'd8) begin
         n_err++; $display("FAIL b2b_en0_done got done=%b cnt=%0d exp done=0 cnt=8", done, shift_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_shr();
      test_rotate();
      test_asr();
      test_enable_clear();
      test_reset_midop();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
